dp_memory_arbiter: RTL and testbench

- Shares one dp_memory_generic instance (port A write-only, port B read-only, 1-cycle registered read) between two requesters (m0, m1).
- Each requester issues one read or write command per cycle over a valid/ready handshake.
- Writes are steered to port A and reads to port B, so one write and one read can both complete in the same cycle.
- Contention for the same port is resolved by independent round-robin pointers, one for writes and one for reads.
- Read data is returned to the issuing requester with a one-cycle response strobe.

---
 rtl/dp_memory_arbiter.sv | 131 +++++++++++++
 tb/tb_dp_memory_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dp_memory_arbiter
// Purpose  : Two-requester arbiter in front of a dual-port memory. Writes go
//            to port A and reads to port B, each with its own round-robin
//            pointer. Read data returns on a one-cycle response strobe.
// Revision : 1.0  initial release
// ============================================================================
module dp_memory_arbiter #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     nreset,

    input  logic                     m0_valid,
    output logic                     m0_ready,
    input  logic                     m0_write,
    input  logic [ADDRESS_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0]    m0_wdata,
    output logic                     m0_rvalid,
    output logic [DATA_WIDTH-1:0]    m0_rdata,

    input  logic                     m1_valid,
    output logic                     m1_ready,
    input  logic                     m1_write,
    input  logic [ADDRESS_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0]    m1_wdata,
    output logic                     m1_rvalid,
    output logic [DATA_WIDTH-1:0]    m1_rdata,

    output logic                     mem_ce_a,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_a,
    output logic [DATA_WIDTH-1:0]    mem_datain,
    output logic                     mem_ce_b,
    output logic                     mem_re,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_b,
    input  logic [DATA_WIDTH-1:0]    mem_dataout
);

    localparam int C_NUM_REQ = 2;

    logic [C_NUM_REQ-1:0] w_valid;
    logic [C_NUM_REQ-1:0] w_write;
    logic [C_NUM_REQ-1:0] w_wr_cand;
    logic [C_NUM_REQ-1:0] w_rd_cand;
    logic [C_NUM_REQ-1:0] w_wr_grant;
    logic [C_NUM_REQ-1:0] w_rd_grant;
    logic [C_NUM_REQ-1:0] w_rvalid;
    logic [DATA_WIDTH-1:0] w_rdata [C_NUM_REQ];

    logic r_wr_ptr;
    logic r_rd_ptr;
    logic r_tag_valid;
    logic r_tag_id;

    // ptr names the requester that wins when both compete
    function automatic logic [1:0] rr_grant(input logic [1:0] cand, input logic ptr);
        logic [1:0] grant;
        grant[0] = cand[0] & (~cand[1] | ~ptr);
        grant[1] = cand[1] & (~cand[0] |  ptr);
        return grant;
    endfunction

    assign w_valid = {m1_valid, m0_valid};
    assign w_write = {m1_write, m0_write};

    // Nothing is granted while reset is held, so the memory stays idle
    assign w_wr_cand = nreset ? (w_valid &  w_write) : 2'b00;
    assign w_rd_cand = nreset ? (w_valid & ~w_write) : 2'b00;

    assign w_wr_grant = rr_grant(w_wr_cand, r_wr_ptr);
    assign w_rd_grant = rr_grant(w_rd_cand, r_rd_ptr);

    assign m0_ready = w_wr_grant[0] | w_rd_grant[0];
    assign m1_ready = w_wr_grant[1] | w_rd_grant[1];

    assign mem_we     = |w_wr_grant;
    assign mem_ce_a   = |w_wr_grant;
    assign mem_addr_a = w_wr_grant[1] ? m1_addr  : m0_addr;
    assign mem_datain = w_wr_grant[1] ? m1_wdata : m0_wdata;

    assign mem_re     = |w_rd_grant;
    assign mem_ce_b   = |w_rd_grant;
    assign mem_addr_b = w_rd_grant[1] ? m1_addr : m0_addr;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_tag_valid <= 1'b0;
            r_tag_id    <= 1'b0;
        end else begin
            if (|w_wr_grant) begin
                r_wr_ptr <= ~w_wr_grant[1];
            end
            if (|w_rd_grant) begin
                r_rd_ptr <= ~w_rd_grant[1];
            end
            r_tag_valid <= |w_rd_grant;
            r_tag_id    <= w_rd_grant[1];
        end
    end

    generate
        for (genvar i = 0; i < C_NUM_REQ; i++) begin : g_resp
            logic [DATA_WIDTH-1:0] r_rdata_hold;

            assign w_rvalid[i] = r_tag_valid & (r_tag_id == 1'(i));

            // Memory output is only meaningful during the strobe; keep a copy after it
            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    r_rdata_hold <= '0;
                end else if (w_rvalid[i]) begin
                    r_rdata_hold <= mem_dataout;
                end
            end

            assign w_rdata[i] = w_rvalid[i] ? mem_dataout : r_rdata_hold;
        end
    endgenerate

    assign m0_rvalid = w_rvalid[0];
    assign m1_rvalid = w_rvalid[1];
    assign m0_rdata  = w_rdata[0];
    assign m1_rdata  = w_rdata[1];

endmodule
`default_nettype wire

// File: tb/tb_dp_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dp_memory_arbiter
// Purpose  : Directed self-checking bench for dp_memory_arbiter with a
//            read-before-write memory model attached to its memory ports.
// Revision : 1.0  initial release
// ============================================================================
module tb_dp_memory_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          clk;
    logic          nreset;
    logic          m0_valid, m0_ready, m0_write, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_valid, m1_ready, m1_write, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          mem_ce_a, mem_we, mem_ce_b, mem_re;
    logic [AW-1:0] mem_addr_a, mem_addr_b;
    logic [DW-1:0] mem_datain, mem_dataout;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    dp_memory_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .nreset(nreset),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_write(m0_write),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_write(m1_write),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_ce_a(mem_ce_a), .mem_we(mem_we), .mem_addr_a(mem_addr_a), .mem_datain(mem_datain),
        .mem_ce_b(mem_ce_b), .mem_re(mem_re), .mem_addr_b(mem_addr_b), .mem_dataout(mem_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered read, old data on same-address write
    always @(posedge clk) begin
        if (mem_ce_b && mem_re) mem_dataout <= mem[mem_addr_b];
        if (mem_ce_a && mem_we) mem[mem_addr_a] <= mem_datain;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        m0_valid = v0; m0_write = w0; m0_addr = a0; m0_wdata = d0;
        m1_valid = v1; m1_write = w1; m1_addr = a1; m1_wdata = d1;
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic apply_reset();
        idle();
        nreset = 1'b0;
        tick();
        tick();
        nreset = 1'b1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        drive(1, 1, 12'h001, 32'h1, 1, 0, 12'h002, 32'h0);
        #2;
        checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL rst_m0_ready got=%b exp=0", m0_ready); end
        checks++; if (m1_ready !== 1'b0) begin errors++; $display("FAIL rst_m1_ready got=%b exp=0", m1_ready); end
        checks++; if ({mem_we, mem_ce_a, mem_re, mem_ce_b} !== 4'b0000) begin errors++; $display("FAIL rst_enables got=%b exp=0000", {mem_we, mem_ce_a, mem_re, mem_ce_b}); end
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got=%b exp=00", {m0_rvalid, m1_rvalid}); end
        checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL rst_m0_rdata got=%h exp=0", m0_rdata); end
        checks++; if (m1_rdata !== 32'h0) begin errors++; $display("FAIL rst_m1_rdata got=%h exp=0", m1_rdata); end
        tick();
        idle();
        nreset = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        drive(1, 1, 12'h005, 32'hDEADBEEF, 0, 0, '0, '0);
        #1;
        checks++; if (m0_ready !== 1'b1) begin errors++; $display("FAIL sw_m0_ready got=%b exp=1", m0_ready); end
        checks++; if ({mem_we, mem_ce_a, mem_re} !== 3'b110) begin errors++; $display("FAIL sw_enables got=%b exp=110", {mem_we, mem_ce_a, mem_re}); end
        checks++; if (mem_addr_a !== 12'h005) begin errors++; $display("FAIL sw_addr_a got=%h exp=005", mem_addr_a); end
        checks++; if (mem_datain !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_datain got=%h exp=deadbeef", mem_datain); end
        tick();
        drive(0, 0, '0, '0, 1, 0, 12'h005, '0);
        #1;
        checks++; if ({m1_ready, mem_re, mem_ce_b} !== 3'b111) begin errors++; $display("FAIL sr_grant got=%b exp=111", {m1_ready, mem_re, mem_ce_b}); end
        checks++; if (mem_addr_b !== 12'h005) begin errors++; $display("FAIL sr_addr_b got=%h exp=005", mem_addr_b); end
        tick();
        idle();
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b01) begin errors++; $display("FAIL sr_rvalid got=%b exp=01", {m1_rvalid, m0_rvalid}); end
        checks++; if (m1_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_rdata got=%h exp=deadbeef", m1_rdata); end
        tick();
        checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL sr_strobe_len got=%b exp=0", m1_rvalid); end
        checks++; if (m1_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_rdata_hold got=%h exp=deadbeef", m1_rdata); end
    endtask

    task automatic test_write_contention();
        apply_reset();
        drive(1, 1, 12'h001, 32'h11, 1, 1, 12'h001, 32'h22);
        #1;
        checks++; if ({m1_ready, m0_ready} !== 2'b01) begin errors++; $display("FAIL wc_c1_ready got=%b exp=01", {m1_ready, m0_ready}); end
        checks++; if (mem_datain !== 32'h11) begin errors++; $display("FAIL wc_c1_datain got=%h exp=11", mem_datain); end
        tick();
        drive(0, 0, '0, '0, 1, 1, 12'h001, 32'h22);
        #1;
        checks++; if ({m1_ready, m0_ready} !== 2'b10) begin errors++; $display("FAIL wc_c2_ready got=%b exp=10", {m1_ready, m0_ready}); end
        checks++; if (mem_datain !== 32'h22) begin errors++; $display("FAIL wc_c2_datain got=%h exp=22", mem_datain); end
        tick();
        drive(1, 0, 12'h001, '0, 0, 0, '0, '0);
        tick();
        idle();
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h22) begin errors++; $display("FAIL wc_readback got=%b/%h exp=1/22", m0_rvalid, m0_rdata); end
        // wr_ptr must be back on requester 0
        drive(1, 1, 12'h009, 32'h99, 1, 1, 12'h00A, 32'hAA);
        #1;
        checks++; if ({m1_ready, m0_ready} !== 2'b01) begin errors++; $display("FAIL wc_ptr_end got=%b exp=01", {m1_ready, m0_ready}); end
        tick();
        drive(0, 0, '0, '0, 1, 1, 12'h00A, 32'hAA);
        tick();
        idle();
    endtask

    task automatic test_read_stream();
        int prev;
        drive(1, 1, 12'h002, 32'hA, 0, 0, '0, '0);
        tick();
        drive(1, 1, 12'h003, 32'hB, 0, 0, '0, '0);
        tick();
        apply_reset();
        drive(1, 0, 12'h002, '0, 1, 0, 12'h003, '0);
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                checks++;
                if ({m1_rvalid, m0_rvalid} !== (prev == 0 ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rs_rvalid k=%0d got=%b prev=%0d", k, {m1_rvalid, m0_rvalid}, prev); end
                checks++;
                if ((prev == 0 ? m0_rdata : m1_rdata) !== (prev == 0 ? 32'hA : 32'hB)) begin errors++; $display("FAIL rs_rdata k=%0d got=%h/%h", k, m0_rdata, m1_rdata); end
            end
            #1;
            checks++;
            if ({m1_ready, m0_ready} !== ((k % 2) == 0 ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rs_grant k=%0d got=%b", k, {m1_ready, m0_ready}); end
            checks++;
            if (mem_addr_b !== ((k % 2) == 0 ? 12'h002 : 12'h003)) begin errors++; $display("FAIL rs_addr_b k=%0d got=%h", k, mem_addr_b); end
            prev = k % 2;
            tick();
        end
        checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hB) begin errors++; $display("FAIL rs_last got=%b/%h exp=1/b", m1_rvalid, m1_rdata); end
        drive(1, 0, 12'h002, '0, 0, 0, '0, '0);
        tick();
        // rd_ptr now favours m1; a write won by m1 must not disturb it
        drive(0, 0, '0, '0, 1, 1, 12'h00C, 32'hC);
        #1;
        checks++; if ({m1_ready, mem_we, mem_re} !== 3'b110) begin errors++; $display("FAIL rs_wr_only got=%b exp=110", {m1_ready, mem_we, mem_re}); end
        tick();
        drive(1, 0, 12'h002, '0, 1, 0, 12'h003, '0);
        #1;
        checks++; if ({m1_ready, m0_ready} !== 2'b10) begin errors++; $display("FAIL rs_ptr_isolated got=%b exp=10", {m1_ready, m0_ready}); end
        tick();
        drive(1, 0, 12'h002, '0, 0, 0, '0, '0);
        checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hB) begin errors++; $display("FAIL rs_iso_data got=%b/%h exp=1/b", m1_rvalid, m1_rdata); end
        tick();
        idle();
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hA) begin errors++; $display("FAIL rs_iso_m0 got=%b/%h exp=1/a", m0_rvalid, m0_rdata); end
        tick();
    endtask

    task automatic test_concurrent();
        drive(1, 1, 12'h007, 32'h01, 0, 0, '0, '0);
        tick();
        drive(1, 1, 12'h007, 32'h77, 1, 0, 12'h007, '0);
        #1;
        checks++; if ({m0_ready, m1_ready, mem_we, mem_re} !== 4'b1111) begin errors++; $display("FAIL cc_both got=%b exp=1111", {m0_ready, m1_ready, mem_we, mem_re}); end
        tick();
        idle();
        checks++; if ({m1_rvalid, m0_rvalid} !== 2'b10) begin errors++; $display("FAIL cc_rvalid got=%b exp=10", {m1_rvalid, m0_rvalid}); end
        checks++; if (m1_rdata !== 32'h01) begin errors++; $display("FAIL cc_old_data got=%h exp=01", m1_rdata); end
        drive(1, 0, 12'h007, '0, 0, 0, '0, '0);
        tick();
        idle();
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h77) begin errors++; $display("FAIL cc_new_data got=%b/%h exp=1/77", m0_rvalid, m0_rdata); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        drive(1, 0, 12'h002, '0, 0, 0, '0, '0);
        #1;
        checks++; if (m0_ready !== 1'b1) begin errors++; $display("FAIL rm_grant got=%b exp=1", m0_ready); end
        tick();
        idle();
        nreset = 1'b0;
        #1;
        checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL rm_rvalid_in_rst got=%b exp=0", m0_rvalid); end
        #1;
        nreset = 1'b1;
        tick();
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL rm_rvalid_after got=%b exp=00", {m0_rvalid, m1_rvalid}); end
        drive(1, 1, 12'h014, 32'h14, 1, 1, 12'h015, 32'h15);
        #1;
        checks++; if ({m1_ready, m0_ready} !== 2'b01) begin errors++; $display("FAIL rm_wr_ptr got=%b exp=01", {m1_ready, m0_ready}); end
        tick();
        drive(1, 0, 12'h002, '0, 1, 0, 12'h003, '0);
        #1;
        checks++; if ({m1_ready, m0_ready} !== 2'b01) begin errors++; $display("FAIL rm_rd_ptr got=%b exp=01", {m1_ready, m0_ready}); end
        tick();
        drive(0, 0, '0, '0, 1, 0, 12'h003, '0);
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hA) begin errors++; $display("FAIL rm_data got=%b/%h exp=1/a", m0_rvalid, m0_rdata); end
        tick();
        idle();
        checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hB) begin errors++; $display("FAIL rm_data_m1 got=%b/%h exp=1/b", m1_rvalid, m1_rdata); end
        tick();
    endtask

    task automatic test_held_valid();
        apply_reset();
        drive(1, 0, 12'h002, '0, 1, 0, 12'h003, '0);
        #1;
        checks++; if ({m1_ready, m0_ready, mem_re} !== 3'b011) begin errors++; $display("FAIL hv_stall got=%b exp=011", {m1_ready, m0_ready, mem_re}); end
        tick();
        drive(0, 0, '0, '0, 1, 0, 12'h003, '0);
        checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hA) begin errors++; $display("FAIL hv_m0_data got=%b/%h exp=1/a", m0_rvalid, m0_rdata); end
        #1;
        checks++; if ({m1_ready, mem_re, mem_ce_b} !== 3'b111) begin errors++; $display("FAIL hv_m1_grant got=%b exp=111", {m1_ready, mem_re, mem_ce_b}); end
        checks++; if (mem_addr_b !== 12'h003) begin errors++; $display("FAIL hv_addr_b got=%h exp=003", mem_addr_b); end
        tick();
        idle();
        checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hB) begin errors++; $display("FAIL hv_m1_data got=%b/%h exp=1/b", m1_rvalid, m1_rdata); end
        #1;
        checks++; if ({mem_re, mem_ce_b, m1_ready} !== 3'b000) begin errors++; $display("FAIL hv_idle got=%b exp=000", {mem_re, mem_ce_b, m1_ready}); end
        tick();
    endtask

    initial begin
        idle();
        nreset = 1'b0;
        test_reset();
        test_single_write();
        test_write_contention();
        test_read_stream();
        test_concurrent();
        test_reset_mid_read();
        test_held_valid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
